// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/func constants, instruction field layout and
// the destination-register write rule used by the decode stage.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNC_SUB = 6'b100010;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_LSB  = 0;
  localparam int IMM_LSB   = 0;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] imm;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [31:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPC_LSB +: 6];
    f.rs     = instr[RS_LSB +: 5];
    f.rt     = instr[RT_LSB +: 5];
    f.rd     = instr[RD_LSB +: 5];
    f.shamt  = instr[SHAMT_LSB +: 5];
    f.func   = instr[FUNC_LSB +: 6];
    f.imm    = instr[IMM_LSB +: 16];
    return f;
  endfunction

  // Branches and stores name a register in rt but never write it back.
  function automatic logic writes_rd(input logic [5:0] opcode, input logic [4:0] rd);
    return (rd != 5'd0) && (opcode != OP_BEQ) && (opcode != OP_BNE) && (opcode != OP_SW);
  endfunction

endpackage

// File: rtl/reg_file.sv
// 2-read/1-write register file; register 0 is hardwired to zero and a write in
// the same cycle as a read of that register is forwarded to the read port.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata_a = regs_q[raddr_a];
    if (raddr_a == '0)                          rdata_a = '0;
    else if (we && (waddr == raddr_a))          rdata_a = wdata;
    rdata_b = regs_q[raddr_b];
    if (raddr_b == '0)                          rdata_b = '0;
    else if (we && (waddr == raddr_b))          rdata_b = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode: splits the instruction, reads rs/rt and holds the result
// in a one-entry ID/EX register with a valid/ready handshake toward the ALU.
module id_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [31:0]       INSTR,
  input  logic              FLUSH,
  input  logic              WB_EN,
  input  logic [REG_AW-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [5:0]        OPCODE,
  output logic [DATA_W-1:0] RS_VAL,
  output logic [DATA_W-1:0] RT_VAL,
  output logic [4:0]        SHAMT,
  output logic [5:0]        FUNC,
  output logic [15:0]       RAW_VAL,
  output logic [REG_AW-1:0] RD_ADDR,
  output logic              WR_EN,
  output logic [CNT_W-1:0]  INSTR_CNT
);

  instr_fields_t     f;
  logic [REG_AW-1:0] rs_addr, rt_addr;
  logic [DATA_W-1:0] rs_rd, rt_rd;
  logic [4:0]        rd_sel;
  logic              accept, stall;

  logic              out_valid_q, out_valid_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d;
  logic [DATA_W-1:0] rt_val_q, rt_val_d;
  logic [4:0]        shamt_q, shamt_d;
  logic [5:0]        func_q, func_d;
  logic [15:0]       raw_q, raw_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign f       = split_instr(INSTR);
  assign rs_addr = REG_AW'(f.rs);
  assign rt_addr = REG_AW'(f.rt);
  assign rd_sel  = (f.opcode == OP_RTYPE) ? f.rd : f.rt;

  assign IN_READY = !out_valid_q || OUT_READY;
  assign accept   = IN_VALID && IN_READY && !FLUSH;
  assign stall    = out_valid_q && !OUT_READY && !FLUSH;

  reg_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk     (CLK),
    .rst_n   (RST_N),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (rs_rd),
    .rdata_b (rt_rd),
    .we      (WB_EN),
    .waddr   (WB_ADDR),
    .wdata   (WB_DATA)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    shamt_d     = shamt_q;
    func_d      = func_q;
    raw_d       = raw_q;
    rd_addr_d   = rd_addr_q;
    wr_en_d     = wr_en_q;
    cnt_d       = cnt_q;

    if (FLUSH)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = 1'b1;
    else if (OUT_READY) out_valid_d = 1'b0;

    if (accept) begin
      opcode_d  = f.opcode;
      rs_addr_d = rs_addr;
      rt_addr_d = rt_addr;
      rs_val_d  = rs_rd;
      rt_val_d  = rt_rd;
      shamt_d   = f.shamt;
      func_d    = f.func;
      raw_d     = f.imm;
      rd_addr_d = REG_AW'(rd_sel);
      wr_en_d   = writes_rd(f.opcode, rd_sel);
      cnt_d     = cnt_q + CNT_W'(1);
    end else if (stall && WB_EN) begin
      // A held entry must not carry operands made stale by a later writeback.
      if ((WB_ADDR == rs_addr_q) && (rs_addr_q != '0)) rs_val_d = WB_DATA;
      if ((WB_ADDR == rt_addr_q) && (rt_addr_q != '0)) rt_val_d = WB_DATA;
    end
  end

  // ID/EX register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      shamt_q     <= '0;
      func_q      <= '0;
      raw_q       <= '0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      shamt_q     <= shamt_d;
      func_q      <= func_d;
      raw_q       <= raw_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      cnt_q       <= cnt_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OPCODE    = opcode_q;
  assign RS_VAL    = rs_val_q;
  assign RT_VAL    = rt_val_q;
  assign SHAMT     = shamt_q;
  assign FUNC      = func_q;
  assign RAW_VAL   = raw_q;
  assign RD_ADDR   = rd_addr_q;
  assign WR_EN     = wr_en_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a register-array/instruction-word model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_id_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              IN_VALID = 1'b0;
  logic              IN_READY;
  logic [31:0]       INSTR = '0;
  logic              FLUSH = 1'b0;
  logic              WB_EN = 1'b0;
  logic [REG_AW-1:0] WB_ADDR = '0;
  logic [DATA_W-1:0] WB_DATA = '0;
  logic              OUT_VALID;
  logic              OUT_READY = 1'b0;
  logic [5:0]        OPCODE;
  logic [DATA_W-1:0] RS_VAL, RT_VAL;
  logic [4:0]        SHAMT;
  logic [5:0]        FUNC;
  logic [15:0]       RAW_VAL;
  logic [REG_AW-1:0] RD_ADDR;
  logic              WR_EN;
  logic [CNT_W-1:0]  INSTR_CNT;

  id_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR(INSTR), .FLUSH(FLUSH), .WB_EN(WB_EN), .WB_ADDR(WB_ADDR),
    .WB_DATA(WB_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OPCODE(OPCODE), .RS_VAL(RS_VAL), .RT_VAL(RT_VAL), .SHAMT(SHAMT),
    .FUNC(FUNC), .RAW_VAL(RAW_VAL), .RD_ADDR(RD_ADDR), .WR_EN(WR_EN),
    .INSTR_CNT(INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: architectural registers and the held instruction word.
  logic [31:0] m_regs [32];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_rs = '0, m_rt = '0;
  logic [31:0] m_cnt = '0;

  function automatic logic [31:0] src_val(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WB_EN && (WB_ADDR == a)) return WB_DATA;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_valid = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic model_step();
    logic acc;
    logic [4:0] hrs, hrt;
    acc = IN_VALID && (!m_valid || OUT_READY) && !FLUSH;
    hrs = m_instr[25:21];
    hrt = m_instr[20:16];
    if (acc) begin
      m_instr = INSTR;
      m_rs    = src_val(INSTR[25:21]);
      m_rt    = src_val(INSTR[20:16]);
      m_cnt   = m_cnt + 1;
    end else if (m_valid && !OUT_READY && !FLUSH && WB_EN) begin
      if (WB_ADDR == hrs && hrs != 0) m_rs = WB_DATA;
      if (WB_ADDR == hrt && hrt != 0) m_rt = WB_DATA;
    end
    if (FLUSH)          m_valid = 1'b0;
    else if (acc)       m_valid = 1'b1;
    else if (OUT_READY) m_valid = 1'b0;
    if (WB_EN && WB_ADDR != 0) m_regs[WB_ADDR] = WB_DATA;
  endtask

  task automatic model_compare();
    logic [5:0] op;
    logic [4:0] rd;
    logic       wr;
    chk("out_valid", {31'd0, OUT_VALID}, {31'd0, m_valid});
    chk("in_ready", {31'd0, IN_READY}, {31'd0, (!m_valid || OUT_READY)});
    chk("instr_cnt", INSTR_CNT, m_cnt);
    if (!RST_N) begin
      chk("rst_rs_val", RS_VAL, 0);
      chk("rst_rt_val", RT_VAL, 0);
      chk("rst_opcode", {26'd0, OPCODE}, 0);
      chk("rst_rd_addr", {27'd0, RD_ADDR}, 0);
      chk("rst_wr_en", {31'd0, WR_EN}, 0);
    end else if (m_valid) begin
      op = m_instr[31:26];
      rd = (op == 6'd0) ? m_instr[15:11] : m_instr[20:16];
      wr = (rd != 0) && (op != 6'h04) && (op != 6'h05) && (op != 6'h2B);
      chk("opcode", {26'd0, OPCODE}, {26'd0, op});
      chk("rs_val", RS_VAL, m_rs);
      chk("rt_val", RT_VAL, m_rt);
      chk("shamt", {27'd0, SHAMT}, {27'd0, m_instr[10:6]});
      chk("func", {26'd0, FUNC}, {26'd0, m_instr[5:0]});
      chk("raw_val", {16'd0, RAW_VAL}, {16'd0, m_instr[15:0]});
      chk("rd_addr", {27'd0, RD_ADDR}, {27'd0, rd});
      chk("wr_en", {31'd0, WR_EN}, {31'd0, wr});
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) model_reset();
      else        model_step();
      #1;
      model_compare();
    end
  end

  task automatic drive(input logic iv, input logic [31:0] ins, input logic fl,
                       input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic ordy);
    IN_VALID  = iv;
    INSTR     = ins;
    FLUSH     = fl;
    WB_EN     = wbe;
    WB_ADDR   = wba;
    WB_DATA   = wbd;
    OUT_READY = ordy;
  endtask

  logic [5:0] ops [6] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h08, 6'h23};

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    chk("lit_rst_valid", {31'd0, OUT_VALID}, 0);
    chk("lit_rst_cnt", INSTR_CNT, 0);
    chk("lit_rst_wr_en", {31'd0, WR_EN}, 0);
    RST_N = 1'b1;
    #1 chk("lit_rst_in_ready", {31'd0, IN_READY}, 1);

    drive(1, 32'h00221822, 0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("lit_t1_valid", {31'd0, OUT_VALID}, 1);
    chk("lit_t1_rs", RS_VAL, 0);
    chk("lit_t1_cnt", INSTR_CNT, 1);

    // Decode sub r3,r1,r2
    drive(0, 0, 0, 1, 5'd1, 52, 1);
    @(negedge CLK);
    drive(0, 0, 0, 1, 5'd2, 4, 1);
    @(negedge CLK);
    drive(1, 32'h00221822, 0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("lit_t2_rs", RS_VAL, 52);
    chk("lit_t2_rt", RT_VAL, 4);
    chk("lit_t2_func", {26'd0, FUNC}, 32'h22);
    chk("lit_t2_rd", {27'd0, RD_ADDR}, 3);
    chk("lit_t2_wr", {31'd0, WR_EN}, 1);
    chk("lit_t2_cnt", INSTR_CNT, 2);

    // Same-cycle bypass, then register 0 stays zero
    drive(1, 32'h20A60000, 0, 1, 5'd5, 150, 1);
    @(negedge CLK);
    chk("lit_t3_bypass", RS_VAL, 150);
    chk("lit_t3_rd", {27'd0, RD_ADDR}, 6);
    drive(0, 0, 0, 1, 5'd0, 99, 1);
    @(negedge CLK);
    drive(1, 32'h20070005, 0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("lit_t3_r0", RS_VAL, 0);
    chk("lit_t3_raw", {16'd0, RAW_VAL}, 5);
    chk("lit_t3_cnt", INSTR_CNT, 4);

    // Stall with writeback into the held rs
    drive(1, 32'h00221822, 0, 0, 0, 0, 1);
    @(negedge CLK);
    drive(1, 32'h20070005, 0, 1, 5'd1, 7, 0);
    #1 chk("lit_t4_in_ready", {31'd0, IN_READY}, 0);
    @(negedge CLK);
    chk("lit_t4_valid", {31'd0, OUT_VALID}, 1);
    chk("lit_t4_cnt", INSTR_CNT, 5);
    chk("lit_t4_rs_patch", RS_VAL, 7);
    chk("lit_t4_opcode", {26'd0, OPCODE}, 0);

    // beq, sw, addi to r0
    drive(1, 32'h1022FFFC, 0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("lit_t5_beq_op", {26'd0, OPCODE}, 4);
    chk("lit_t5_beq_raw", {16'd0, RAW_VAL}, 32'hFFFC);
    chk("lit_t5_beq_rd", {27'd0, RD_ADDR}, 2);
    chk("lit_t5_beq_wr", {31'd0, WR_EN}, 0);
    chk("lit_t5_cnt", INSTR_CNT, 6);
    drive(1, 32'hAC220008, 0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("lit_t5_sw_wr", {31'd0, WR_EN}, 0);
    drive(1, 32'h20200001, 0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("lit_t5_addi_r0_wr", {31'd0, WR_EN}, 0);
    chk("lit_t5_cnt2", INSTR_CNT, 8);

    // Flush with held entry, incoming instruction and a writeback
    drive(1, 32'h00221822, 1, 1, 5'd9, 32'h1234, 0);
    @(negedge CLK);
    chk("lit_t6_valid", {31'd0, OUT_VALID}, 0);
    chk("lit_t6_cnt", INSTR_CNT, 8);
    drive(1, 32'h01205020, 0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("lit_t6_wb_kept", RS_VAL, 32'h1234);
    chk("lit_t6_cnt2", INSTR_CNT, 9);

    // Asynchronous reset in the middle of a stall
    drive(1, 32'h00221822, 0, 0, 0, 0, 1);
    @(negedge CLK);
    drive(1, 32'h00221822, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("lit_t7_stalled", {31'd0, OUT_VALID}, 1);
    #3 RST_N = 1'b0;
    #1 chk("lit_t7_async_valid", {31'd0, OUT_VALID}, 0);
    chk("lit_t7_async_cnt", INSTR_CNT, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    drive(1, 32'h00221822, 0, 0, 0, 0, 1);
    @(negedge CLK);
    chk("lit_t7_rf_cleared", RS_VAL, 0);
    chk("lit_t7_cnt", INSTR_CNT, 1);

    // Random traffic against the model
    repeat (3000) begin
      logic [31:0] lo;
      lo = $urandom;
      drive(($urandom_range(0, 9) < 7),
            {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), lo[10:0]},
            ($urandom_range(0, 19) == 0),
            $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)),
            $urandom,
            ($urandom_range(0, 9) < 6));
      @(negedge CLK);
    end

    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
